addsub_multicycle: RTL



---
 rtl/addsub_pkg.sv | 36 +++
 rtl/addsub_multicycle_if.sv | 38 +++
 rtl/addsub_chunk.sv | 37 +++
 rtl/addsub_multicycle.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// -----------------------------------------------------------------------------
// addsub_pkg
// Shared definitions for the iterative add/subtract unit:
//   - operation encodings (OP_ADD / OP_SUB)
//   - control FSM state encoding
//   - helper returning the signed saturation limits for a given width
// -----------------------------------------------------------------------------
package addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Widest result the saturation helper can describe.
    localparam int unsigned SAT_MAX_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    // Signed extreme for a width-bit two's-complement value:
    // neg=1 -> most negative (100..0), neg=0 -> most positive (011..1).
    // The caller truncates the returned value to its own width.
    function automatic logic [SAT_MAX_W-1:0] sat_limit(input int unsigned width,
                                                       input logic        neg);
        logic [SAT_MAX_W-1:0] msb_s;
        msb_s = {{(SAT_MAX_W-1){1'b0}}, 1'b1} << (width - 32'd1);
        if (neg) begin
            return msb_s;
        end else begin
            return msb_s - {{(SAT_MAX_W-1){1'b0}}, 1'b1};
        end
    endfunction

endpackage

// File: rtl/addsub_multicycle_if.sv
// -----------------------------------------------------------------------------
// addsub_multicycle_if
// Handshake and data bundle of the iterative add/subtract unit.
//   START  request (sampled only while the unit is not busy)
//   OP     0 = add, 1 = subtract
//   A, B   operands (WIDTH bits)
//   BUSY   operation in progress
//   DONE   one-cycle completion pulse
//   RESULT final sum/difference, held until the next completion
//   CARRY  carry-out (add) / borrow (sub)
//   ZERO, NEG, OVF  result flags
// Modports: master = requester (control FSM), slave = the arithmetic unit.
// -----------------------------------------------------------------------------
interface addsub_multicycle_if #(
    parameter int WIDTH = 16
);
    logic             START;
    logic             OP;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] RESULT;
    logic             CARRY;
    logic             ZERO;
    logic             NEG;
    logic             OVF;

    modport master (
        output START, OP, A, B,
        input  BUSY, DONE, RESULT, CARRY, ZERO, NEG, OVF
    );

    modport slave (
        input  START, OP, A, B,
        output BUSY, DONE, RESULT, CARRY, ZERO, NEG, OVF
    );
endinterface

// File: rtl/addsub_chunk.sv
// -----------------------------------------------------------------------------
// addsub_chunk
// Combinational CHUNK-bit ripple adder slice.
//   a, b      chunk operands
//   cin       carry in
//   sum       chunk sum
//   cout      carry out of the top bit
//   c_msb_in  carry into the top bit (used for signed overflow on the last chunk)
// -----------------------------------------------------------------------------
module addsub_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    logic [CHUNK:0] c_s;

    // Bit-serial ripple: c_s[i] is the carry into bit i.
    always_comb begin
        c_s    = {(CHUNK+1){1'b0}};
        sum    = {CHUNK{1'b0}};
        c_s[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c_s[i];
            c_s[i+1] = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
        end
    end

    assign cout     = c_s[CHUNK];
    assign c_msb_in = c_s[CHUNK-1];

endmodule

// File: rtl/addsub_multicycle.sv
// -----------------------------------------------------------------------------
// addsub_multicycle
// Iterative add/subtract unit. Operands are latched on an accepted START and
// processed CHUNK bits per clock, LSB first, through a registered carry. The
// full result and flags are written only on the final processing edge, then
// DONE pulses for one cycle (a START in that cycle is accepted back-to-back).
//
// Parameters:
//   WIDTH  operand/result width (>= 2)
//   CHUNK  bits per cycle, must divide WIDTH; N = WIDTH/CHUNK processing edges
// Ports:
//   CLK    rising-edge clock
//   RST    synchronous active-high reset (aborts any operation, no DONE)
//   bus    addsub_multicycle_if.slave (START/OP/A/B in, BUSY/DONE/RESULT/flags out)
// Build option:
//   ADDSUB_MULTICYCLE_SAT_EN  when defined, a signed overflow clamps RESULT to
//                             the signed extreme selected by the sign of A;
//                             otherwise the result wraps.
// -----------------------------------------------------------------------------
module addsub_multicycle
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             CLK,
    input  logic             RST,
    addsub_multicycle_if.slave bus
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    if (WIDTH < 2) begin : g_bad_width
        $error("addsub_multicycle: WIDTH must be at least 2");
    end
    if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_chunk
        $error("addsub_multicycle: CHUNK must divide WIDTH");
    end

    state_t             state_r;
    state_t             state_nx_s;
    logic [IDX_W-1:0]   idx_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;          // B for add, ~B for subtract
    logic               op_r;
    logic               carry_r;
    logic [WIDTH-1:0]   acc_r;

    logic               busy_r;
    logic               done_r;
    logic [WIDTH-1:0]   result_r;
    logic               carry_flag_r;
    logic               zero_r;
    logic               neg_r;
    logic               ovf_r;

    logic               accept_s;
    logic               last_s;
    logic [31:0]        base_s;
    logic [CHUNK-1:0]   a_chunk_s;
    logic [CHUNK-1:0]   b_chunk_s;
    logic [CHUNK-1:0]   sum_s;
    logic               cout_s;
    logic               c_msb_s;
    logic [WIDTH-1:0]   acc_nx_s;
    logic [WIDTH-1:0]   res_s;
    logic               ovf_s;

    // A request is only seen in IDLE or in the DONE cycle; START while busy is dropped.
    assign accept_s = bus.START && ((state_r == ST_IDLE) || (state_r == ST_FIN));
    assign last_s   = (state_r == ST_BUSY) && (idx_r == IDX_W'(N - 1));
    assign base_s   = 32'(idx_r) * 32'(CHUNK);

    // Select the chunk currently being processed.
    always_comb begin
        a_chunk_s = a_r[base_s +: CHUNK];
        b_chunk_s = b_r[base_s +: CHUNK];
    end

    addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a        (a_chunk_s),
        .b        (b_chunk_s),
        .cin      (carry_r),
        .sum      (sum_s),
        .cout     (cout_s),
        .c_msb_in (c_msb_s)
    );

    // Accumulator with the current chunk's sum merged in; on the last edge this is the full result.
    always_comb begin
        acc_nx_s                  = acc_r;
        acc_nx_s[base_s +: CHUNK] = sum_s;
    end

    // Final result, with optional clamp on signed overflow.
    always_comb begin
        ovf_s = c_msb_s ^ cout_s;
        res_s = acc_nx_s;
`ifdef ADDSUB_MULTICYCLE_SAT_EN
        if (ovf_s) begin
            res_s = WIDTH'(sat_limit(WIDTH, a_r[WIDTH-1]));
        end else begin
            res_s = acc_nx_s;
        end
`endif
    end

    // Next-state decode of the control FSM.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nx_s = ST_BUSY;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (last_s) begin
                    state_nx_s = ST_FIN;
                end else begin
                    state_nx_s = ST_BUSY;
                end
            end
            ST_FIN: begin
                if (accept_s) begin
                    state_nx_s = ST_BUSY;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Operand latch, chunk index and registered carry chain.
    always_ff @(posedge CLK) begin
        if (RST) begin
            idx_r   <= {IDX_W{1'b0}};
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            op_r    <= 1'b0;
            carry_r <= 1'b0;
            acc_r   <= {WIDTH{1'b0}};
        end else if (accept_s) begin
            idx_r   <= {IDX_W{1'b0}};
            a_r     <= bus.A;
            b_r     <= (bus.OP == OP_SUB) ? ~bus.B : bus.B;
            op_r    <= bus.OP;
            carry_r <= bus.OP;               // +1 completes the two's complement of B
            acc_r   <= {WIDTH{1'b0}};
        end else if (state_r == ST_BUSY) begin
            acc_r   <= acc_nx_s;
            carry_r <= cout_s;
            idx_r   <= last_s ? {IDX_W{1'b0}} : (idx_r + IDX_W'(1));
        end
    end

    // Registered handshake outputs and result/flags (updated only on the final edge).
    always_ff @(posedge CLK) begin
        if (RST) begin
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            result_r     <= {WIDTH{1'b0}};
            carry_flag_r <= 1'b0;
            zero_r       <= 1'b0;
            neg_r        <= 1'b0;
            ovf_r        <= 1'b0;
        end else begin
            busy_r <= (state_nx_s == ST_BUSY);
            done_r <= (state_nx_s == ST_FIN);
            if (last_s) begin
                result_r     <= res_s;
                // Subtract reports borrow, which is the inverse of the adder carry.
                carry_flag_r <= (op_r == OP_SUB) ? ~cout_s : cout_s;
                zero_r       <= (res_s == {WIDTH{1'b0}});
                neg_r        <= res_s[WIDTH-1];
                ovf_r        <= ovf_s;
            end
        end
    end

    assign bus.BUSY   = busy_r;
    assign bus.DONE   = done_r;
    assign bus.RESULT = result_r;
    assign bus.CARRY  = carry_flag_r;
    assign bus.ZERO   = zero_r;
    assign bus.NEG    = neg_r;
    assign bus.OVF    = ovf_r;

endmodule
